// File: rtl/writeback_pkg.sv
// writeback_pkg: shared codes, types and helpers for the commit stage
package writeback_pkg;
    localparam logic [1:0] DEST_NONE = 2'd0;
    localparam logic [1:0] DEST_REG  = 2'd1;
    localparam logic [1:0] DEST_MEM  = 2'd2;
    localparam logic [1:0] WIDTH_8   = 2'd0;
    localparam logic [1:0] WIDTH_16  = 2'd1;
    localparam logic [1:0] WIDTH_32  = 2'd2;
    localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

    typedef enum logic [1:0] {WB_IDLE, WB_MEM0, WB_MEM1, WB_RETIRE} wb_state_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [1:0]  width;
    } dest_t;

    typedef struct packed {
        logic [31:0] opnd0;
        logic [31:0] opnd1;
        logic [31:0] eflags;
        logic [31:0] eip;
        dest_t       dest0;
        dest_t       dest1;
    } instr_t;

    function automatic logic [3:0] width_mask(input logic [1:0] w);
        return w == WIDTH_8 ? 4'b0001 : w == WIDTH_16 ? 4'b0011 : 4'b1111;
    endfunction

    // 8-bit selectors 4-7 name AH/CH/DH/BH, i.e. bits [15:8] of GPR sel-4
    function automatic logic is_hi8(input dest_t d);
        return d.width == WIDTH_8 && d.sel[2];
    endfunction

    function automatic logic [2:0] gpr_index(input dest_t d);
        return is_hi8(d) ? {1'b0, d.sel[1:0]} : d.sel;
    endfunction
endpackage

// File: rtl/writeback_gpr_merge.sv
// gpr_merge: merges a partial-width write into an existing 32-bit register value
module gpr_merge
    import writeback_pkg::*;
(
    input  logic [31:0] old_val,
    input  logic [31:0] new_val,
    input  logic [1:0]  width,
    input  logic        hi8,
    output logic [31:0] merged
);
    always_comb begin
        merged = width == WIDTH_8  ? (hi8 ? {old_val[31:16], new_val[7:0], old_val[7:0]}
                                          : {old_val[31:8], new_val[7:0]}) :
                 width == WIDTH_16 ? {old_val[31:16], new_val[15:0]} : new_val;
    end
endmodule

// File: rtl/writeback.sv
// writeback: commit stage that performs stores, then atomically updates GPRs, EFLAGS and EIP
module writeback
    import writeback_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000,
    parameter logic [31:0] RESET_ESP = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  opnd0_w,
    input  logic [31:0]  opnd1_w,
    input  logic [31:0]  eflags_in,
    input  logic [31:0]  next_eip,
    input  logic [1:0]   dest0_kind,
    input  logic [2:0]   dest0_sel,
    input  logic [31:0]  dest0_addr,
    input  logic [1:0]   dest0_width,
    input  logic [1:0]   dest1_kind,
    input  logic [2:0]   dest1_sel,
    input  logic [31:0]  dest1_addr,
    input  logic [1:0]   dest1_width,
    output logic         mem_wr_valid,
    input  logic         mem_wr_ready,
    output logic [31:0]  mem_wr_addr,
    output logic [31:0]  mem_wr_data,
    output logic [3:0]   mem_wr_mask,
    output logic [255:0] gpr_flat,
    output logic [31:0]  eflags,
    output logic [31:0]  eip,
    output logic         retired,
    output logic [31:0]  retire_count
);
    wb_state_e         state_q, state_d;
    instr_t            hold_q, hold_d, in_instr;
    logic [7:0][31:0]  gpr_q, gpr_d, gpr_mid, gpr_commit;
    logic [31:0]       eflags_q, eflags_d, eip_q, eip_d, count_q, count_d;
    logic              retired_q, retired_d;
    logic [31:0]       merged0, merged1;
    logic [2:0]        idx0, idx1;
    dest_t             cur;

    always_comb begin
        in_instr.opnd0       = opnd0_w;
        in_instr.opnd1       = opnd1_w;
        in_instr.eflags      = eflags_in;
        in_instr.eip         = next_eip;
        in_instr.dest0.kind  = dest0_kind;
        in_instr.dest0.sel   = dest0_sel;
        in_instr.dest0.addr  = dest0_addr;
        in_instr.dest0.width = dest0_width;
        in_instr.dest1.kind  = dest1_kind;
        in_instr.dest1.sel   = dest1_sel;
        in_instr.dest1.addr  = dest1_addr;
        in_instr.dest1.width = dest1_width;
    end

    assign idx0 = gpr_index(hold_q.dest0);
    assign idx1 = gpr_index(hold_q.dest1);

    // dest1 lands first so a dest0 write to the same GPR overrides it
    gpr_merge u_merge1 (
        .old_val (gpr_q[idx1]),
        .new_val (hold_q.opnd1),
        .width   (hold_q.dest1.width),
        .hi8     (is_hi8(hold_q.dest1)),
        .merged  (merged1)
    );

    gpr_merge u_merge0 (
        .old_val (gpr_mid[idx0]),
        .new_val (hold_q.opnd0),
        .width   (hold_q.dest0.width),
        .hi8     (is_hi8(hold_q.dest0)),
        .merged  (merged0)
    );

    always_comb begin
        gpr_mid = gpr_q;
        if (hold_q.dest1.kind == DEST_REG) gpr_mid[idx1] = merged1;
    end

    always_comb begin
        gpr_commit = gpr_mid;
        if (hold_q.dest0.kind == DEST_REG) gpr_commit[idx0] = merged0;
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gpr_d     = gpr_q;
        eflags_d  = eflags_q;
        eip_d     = eip_q;
        count_d   = count_q;
        retired_d = 1'b0;
        case (state_q)
            WB_IDLE: if (in_valid) begin
                hold_d  = in_instr;
                state_d = dest0_kind == DEST_MEM ? WB_MEM0 :
                          dest1_kind == DEST_MEM ? WB_MEM1 : WB_RETIRE;
            end
            WB_MEM0: if (mem_wr_ready)
                state_d = hold_q.dest1.kind == DEST_MEM ? WB_MEM1 : WB_RETIRE;
            WB_MEM1: if (mem_wr_ready) state_d = WB_RETIRE;
            WB_RETIRE: begin
                gpr_d     = gpr_commit;
                eflags_d  = hold_q.eflags | 32'h0000_0002;
                eip_d     = hold_q.eip;
                count_d   = count_q + 32'd1;
                retired_d = 1'b1;
                state_d   = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            hold_q    <= '0;
            gpr_q     <= '0;
            gpr_q[4]  <= RESET_ESP;
            eflags_q  <= EFLAGS_RESET;
            eip_q     <= RESET_EIP;
            count_q   <= '0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gpr_q     <= gpr_d;
            eflags_q  <= eflags_d;
            eip_q     <= eip_d;
            count_q   <= count_d;
            retired_q <= retired_d;
        end
    end

    // store port is decoded straight from the state so reset drops it at once
    always_comb begin
        cur          = state_q == WB_MEM1 ? hold_q.dest1 : hold_q.dest0;
        mem_wr_valid = state_q == WB_MEM0 || state_q == WB_MEM1;
        mem_wr_addr  = mem_wr_valid ? cur.addr : '0;
        mem_wr_data  = !mem_wr_valid ? '0 : state_q == WB_MEM1 ? hold_q.opnd1 : hold_q.opnd0;
        mem_wr_mask  = mem_wr_valid ? width_mask(cur.width) : '0;
    end

    assign in_ready     = state_q == WB_IDLE;
    assign gpr_flat     = gpr_q;
    assign eflags       = eflags_q;
    assign eip          = eip_q;
    assign retired      = retired_q;
    assign retire_count = count_q;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed self-checking bench for the writeback commit stage
module tb_writeback;
    localparam logic [31:0] R_EIP = 32'h0000_1000;
    localparam logic [31:0] R_ESP = 32'h0000_8000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [31:0]  opnd0_w = '0, opnd1_w = '0, eflags_in = '0, next_eip = '0;
    logic [1:0]   dest0_kind = '0, dest0_width = '0, dest1_kind = '0, dest1_width = '0;
    logic [2:0]   dest0_sel = '0, dest1_sel = '0;
    logic [31:0]  dest0_addr = '0, dest1_addr = '0;
    logic         mem_wr_valid, mem_wr_ready = 1'b0;
    logic [31:0]  mem_wr_addr, mem_wr_data;
    logic [3:0]   mem_wr_mask;
    logic [255:0] gpr_flat;
    logic [31:0]  eflags, eip, retire_count;
    logic         retired;
    int           vectors = 0, errors = 0;

    always #5 clk = ~clk;

    writeback #(.RESET_EIP(R_EIP), .RESET_ESP(R_ESP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opnd0_w(opnd0_w), .opnd1_w(opnd1_w), .eflags_in(eflags_in), .next_eip(next_eip),
        .dest0_kind(dest0_kind), .dest0_sel(dest0_sel), .dest0_addr(dest0_addr), .dest0_width(dest0_width),
        .dest1_kind(dest1_kind), .dest1_sel(dest1_sel), .dest1_addr(dest1_addr), .dest1_width(dest1_width),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask), .gpr_flat(gpr_flat),
        .eflags(eflags), .eip(eip), .retired(retired), .retire_count(retire_count)
    );

    function automatic logic [31:0] gpr(input int i);
        return gpr_flat[32*i +: 32];
    endfunction

    // Presents one instruction at a negedge, returns at the negedge after it was accepted
    task automatic send(input logic [1:0] k0, input logic [2:0] s0, input logic [31:0] a0,
                        input logic [1:0] w0, input logic [31:0] v0,
                        input logic [1:0] k1, input logic [2:0] s1, input logic [31:0] a1,
                        input logic [1:0] w1, input logic [31:0] v1,
                        input logic [31:0] fl, input logic [31:0] ip);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b want 1", in_ready); end
        dest0_kind = k0; dest0_sel = s0; dest0_addr = a0; dest0_width = w0; opnd0_w = v0;
        dest1_kind = k1; dest1_sel = s1; dest1_addr = a1; dest1_width = w1; opnd1_w = v1;
        eflags_in = fl; next_eip = ip; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (gpr(i) !== (i == 4 ? R_ESP : 32'h0)) begin errors++; $display("FAIL reset_gpr%0d: got %h want %h", i, gpr(i), (i == 4 ? R_ESP : 32'h0)); end
        end
        vectors++; if (eip !== R_EIP) begin errors++; $display("FAIL reset_eip: got %h want %h", eip, R_EIP); end
        vectors++; if (eflags !== 32'h2) begin errors++; $display("FAIL reset_eflags: got %h want 2", eflags); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (retire_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", retire_count); end
        vectors++; if ({retired, mem_wr_valid, mem_wr_mask, mem_wr_addr, mem_wr_data} !== '0) begin errors++; $display("FAIL reset_outputs: got %b %b %h %h %h want zeros", retired, mem_wr_valid, mem_wr_mask, mem_wr_addr, mem_wr_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reg_commit();
        send(2'd1, 3'd0, 32'h0, 2'd2, 32'hDEAD_BEEF, 2'd0, 3'd0, 32'h0, 2'd2, 32'h0, 32'h41, 32'h1005);
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reg_busy: in_ready=%b want 0", in_ready); end
        vectors++; if (eip !== R_EIP || retired !== 1'b0) begin errors++; $display("FAIL reg_early: eip=%h retired=%b want %h 0", eip, retired, R_EIP); end
        @(negedge clk);
        vectors++; if (gpr(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reg_eax: got %h want deadbeef", gpr(0)); end
        vectors++; if (eflags !== 32'h43) begin errors++; $display("FAIL reg_eflags: got %h want 43", eflags); end
        vectors++; if (eip !== 32'h1005) begin errors++; $display("FAIL reg_eip: got %h want 1005", eip); end
        vectors++; if (retired !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL reg_retired: retired=%b in_ready=%b want 1 1", retired, in_ready); end
        vectors++; if (retire_count !== 32'd1) begin errors++; $display("FAIL reg_count: got %0d want 1", retire_count); end
        @(negedge clk);
        vectors++; if (retired !== 1'b0) begin errors++; $display("FAIL reg_pulse: retired=%b want 0", retired); end
    endtask

    task automatic test_partial();
        send(2'd1, 3'd3, 32'h0, 2'd2, 32'h1122_3344, 2'd0, 3'd0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h1010);
        @(negedge clk);
        send(2'd1, 3'd7, 32'h0, 2'd0, 32'hFFFF_FFAA, 2'd0, 3'd0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h1012);
        @(negedge clk);
        vectors++; if (gpr(3) !== 32'h1122_AA44) begin errors++; $display("FAIL partial_bh: got %h want 1122aa44", gpr(3)); end
        vectors++; if (gpr(7) !== 32'h0) begin errors++; $display("FAIL partial_edi: got %h want 0", gpr(7)); end
        send(2'd1, 3'd3, 32'h0, 2'd1, 32'hFFFF_5566, 2'd0, 3'd0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h1014);
        @(negedge clk);
        vectors++; if (gpr(3) !== 32'h1122_5566) begin errors++; $display("FAIL partial_bx: got %h want 11225566", gpr(3)); end
        send(2'd1, 3'd3, 32'h0, 2'd0, 32'h0000_0077, 2'd0, 3'd0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h1016);
        @(negedge clk);
        vectors++; if (gpr(3) !== 32'h1122_5577) begin errors++; $display("FAIL partial_bl: got %h want 11225577", gpr(3)); end
        vectors++; if (retire_count !== 32'd5) begin errors++; $display("FAIL partial_count: got %0d want 5", retire_count); end
    endtask

    task automatic test_call();
        mem_wr_ready = 1'b0;
        send(2'd2, 3'd0, 32'h0FFC, 2'd2, 32'h2000, 2'd1, 3'd4, 32'h0, 2'd2, 32'h0FFC, 32'h0, 32'h2000);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_wr_ready = 1'b1;
            vectors++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'hFFC || mem_wr_data !== 32'h2000 || mem_wr_mask !== 4'hF) begin errors++; $display("FAIL call_store%0d: v=%b a=%h d=%h m=%h want 1 ffc 2000 f", i, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask); end
            vectors++; if (gpr(4) !== R_ESP || eip !== 32'h1016) begin errors++; $display("FAIL call_early%0d: esp=%h eip=%h want %h 1016", i, gpr(4), eip, R_ESP); end
            @(negedge clk);
        end
        mem_wr_ready = 1'b0;
        vectors++; if (mem_wr_valid !== 1'b0 || gpr(4) !== R_ESP) begin errors++; $display("FAIL call_retire_stage: v=%b esp=%h want 0 %h", mem_wr_valid, gpr(4), R_ESP); end
        @(negedge clk);
        vectors++; if (gpr(4) !== 32'hFFC || eip !== 32'h2000) begin errors++; $display("FAIL call_commit: esp=%h eip=%h want ffc 2000", gpr(4), eip); end
    endtask

    task automatic test_back_to_back();
        mem_wr_ready = 1'b1;
        send(2'd2, 3'd0, 32'h10, 2'd0, 32'h1234_56AB, 2'd2, 3'd0, 32'h20, 2'd1, 32'h0000_CCDD, 32'h0, 32'h2004);
        vectors++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h10 || mem_wr_mask !== 4'b0001 || mem_wr_data !== 32'h1234_56AB || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: v=%b a=%h m=%b d=%h r=%b want 1 10 0001 123456ab 0", mem_wr_valid, mem_wr_addr, mem_wr_mask, mem_wr_data, in_ready); end
        @(negedge clk);
        vectors++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h20 || mem_wr_mask !== 4'b0011 || mem_wr_data !== 32'hCCDD || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second: v=%b a=%h m=%b d=%h r=%b want 1 20 0011 ccdd 0", mem_wr_valid, mem_wr_addr, mem_wr_mask, mem_wr_data, in_ready); end
        @(negedge clk);
        vectors++; if (mem_wr_valid !== 1'b0 || in_ready !== 1'b0 || retired !== 1'b0) begin errors++; $display("FAIL b2b_retire_stage: v=%b r=%b ret=%b want 0 0 0", mem_wr_valid, in_ready, retired); end
        @(negedge clk);
        vectors++; if (retired !== 1'b1 || eip !== 32'h2004 || retire_count !== 32'd7) begin errors++; $display("FAIL b2b_commit: ret=%b eip=%h cnt=%0d want 1 2004 7", retired, eip, retire_count); end
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_conflict();
        send(2'd1, 3'd2, 32'h0, 2'd2, 32'h1, 2'd1, 3'd2, 32'h0, 2'd2, 32'h2, 32'h0, 32'h2008);
        @(negedge clk);
        vectors++; if (gpr(2) !== 32'h1) begin errors++; $display("FAIL conflict_edx: got %h want 1", gpr(2)); end
    endtask

    task automatic test_reserved();
        send(2'd3, 3'd1, 32'h30, 2'd2, 32'hFFFF_FFFF, 2'd3, 3'd1, 32'h34, 2'd2, 32'hFFFF_FFFF, 32'h0, 32'h200C);
        vectors++; if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL reserved_nostore: v=%b want 0", mem_wr_valid); end
        @(negedge clk);
        vectors++; if (gpr(1) !== 32'h0 || retire_count !== 32'd9) begin errors++; $display("FAIL reserved_kind: ecx=%h cnt=%0d want 0 9", gpr(1), retire_count); end
        send(2'd1, 3'd1, 32'h0, 2'd3, 32'h1234_5678, 2'd0, 3'd0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h2010);
        @(negedge clk);
        vectors++; if (gpr(1) !== 32'h1234_5678) begin errors++; $display("FAIL reserved_width: ecx=%h want 12345678", gpr(1)); end
    endtask

    task automatic test_reset_mid();
        mem_wr_ready = 1'b0;
        send(2'd2, 3'd0, 32'h40, 2'd2, 32'h5555_AAAA, 2'd1, 3'd0, 32'h0, 2'd2, 32'h9, 32'h0, 32'h3000);
        vectors++; if (mem_wr_valid !== 1'b1) begin errors++; $display("FAIL mid_stall: v=%b want 1", mem_wr_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (mem_wr_valid !== 1'b0 || mem_wr_mask !== 4'h0 || mem_wr_addr !== 32'h0) begin errors++; $display("FAIL mid_async: v=%b m=%h a=%h want 0 0 0", mem_wr_valid, mem_wr_mask, mem_wr_addr); end
        vectors++; if (eip !== R_EIP || eflags !== 32'h2 || retire_count !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_state: eip=%h fl=%h cnt=%0d r=%b want %h 2 0 1", eip, eflags, retire_count, in_ready, R_EIP); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (gpr(i) !== (i == 4 ? R_ESP : 32'h0)) begin errors++; $display("FAIL mid_gpr%0d: got %h want %h", i, gpr(i), (i == 4 ? R_ESP : 32'h0)); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_wr_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++; if (retired !== 1'b0 || mem_wr_valid !== 1'b0 || gpr(0) !== 32'h0) begin errors++; $display("FAIL mid_discard: ret=%b v=%b eax=%h want 0 0 0", retired, mem_wr_valid, gpr(0)); end
        end
        vectors++; if (retire_count !== 32'h0 || eip !== R_EIP) begin errors++; $display("FAIL mid_after: cnt=%0d eip=%h want 0 %h", retire_count, eip, R_EIP); end
    endtask

    initial begin
        test_reset();
        test_reg_commit();
        test_partial();
        test_call();
        test_back_to_back();
        test_conflict();
        test_reserved();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Commit stage downstream of the execute stage.
- Accepts one executed instruction per valid/ready handshake: write operands, resulting EFLAGS, next EIP and two destination descriptors.
- Performs memory writes over a valid/ready store port, then atomically updates the architectural GPR file, EFLAGS and EIP.
- Owns the architectural register state that feeds operand fetch for the next step.

Parameters:
RESET_EIP, 32'h0000_0000, EIP value loaded on reset.
RESET_ESP, 32'h0000_0000, ESP (GPR 4) value loaded on reset; all other GPRs reset to 0.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  execute result available.
in_ready  out  1  writeback can accept a result.
opnd0_w  in  32  value for destination 0.
opnd1_w  in  32  value for destination 1.
eflags_in  in  32  EFLAGS produced by execute.
next_eip  in  32  EIP produced by the control-flow unit.
dest0_kind  in  2  0=NONE, 1=REG, 2=MEM, 3=reserved (treated as NONE).
dest0_sel  in  3  GPR index, x86 encoding.
dest0_addr  in  32  linear byte address when kind=MEM.
dest0_width  in  2  0=8-bit, 1=16-bit, 2=32-bit, 3=reserved (treated as 32).
dest1_kind, dest1_sel, dest1_addr, dest1_width  in  2/3/32/2  same meanings, destination 1.
mem_wr_valid  out  1  store request.
mem_wr_ready  in  1  store accepted.
mem_wr_addr  out  32  store address.
mem_wr_data  out  32  store data, LSB-aligned.
mem_wr_mask  out  4  byte enables.
gpr_flat  out  256  GPRs; register i occupies bits [32i+31:32i].
eflags  out  32  architectural EFLAGS.
eip  out  32  architectural EIP.
retired  out  1  one-cycle pulse per committed instruction.
retire_count  out  32  committed-instruction counter.

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; mem_wr_valid=0; mem_wr_addr, mem_wr_data and mem_wr_mask all 0.
  - GPRs 0, except GPR4=RESET_ESP.
  - eflags=32'h0000_0002 (bit 1 reserved-one); eip=RESET_EIP.
  - retired=0; retire_count=0.
- FSM states: IDLE, MEM0, MEM1, RETIRE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch every input into holding registers.
  - Next state: MEM0 if dest0 is MEM, else MEM1 if dest1 is MEM, else RETIRE.
- In_ready rule: in_ready=0 in every state other than IDLE; inputs are ignored there.
- MEM0/MEM1 (store handshake):
  - Assert mem_wr_valid with addr, data and mask from the held destination.
  - Valid and the payload stay stable until mem_wr_ready is sampled high; valid is never retracted.
  - A transfer completes in the same cycle valid and ready are both high.
  - After MEM0 completes: go to MEM1 if dest1 is MEM, else RETIRE. After MEM1 completes: go to RETIRE.
  - mem_wr_valid deasserts in the cycle after completion unless the next state is MEM1.
- Mask and data by width: 8 -> 4'b0001, 16 -> 4'b0011, 32 -> 4'b1111. Data is the held opnd value, unshifted. Address is passed through unmodified; alignment is not checked.
- RETIRE (single cycle):
  - Apply the REG destinations: dest1 first, then dest0, so dest0 wins when both name the same GPR.
  - Update eflags<=eflags_in (bit 1 forced to 1) and eip<=next_eip.
  - Pulse retired=1.
  - retire_count increments by 1 and wraps from 32'hFFFF_FFFF to 0.
  - Next state: IDLE.
- Partial register merge:
  - width32: whole register.
  - width16: bits[15:0] of reg sel.
  - width8, sel 0-3: bits[7:0] of reg sel.
  - width8, sel 4-7: bits[15:8] of reg (sel-4), i.e. AH/CH/DH/BH.
  - Unselected bits are preserved.
- Latency:
  - No MEM destinations: accept at cycle T, state visible at T+2, in_ready high again at T+2.
  - Each store adds at least one cycle plus ready stall cycles.
- Atomicity: architectural outputs change only at the RETIRE edge. Stores complete before any register, EFLAGS or EIP update.
- Reset mid-operation: the FSM is abandoned, mem_wr_valid drops immediately (asynchronously), all state returns to reset values, and the held instruction is discarded without commit.

Decomposition:
- Add to defines.v:
  - DEST_NONE/REG/MEM kind codes.
  - WIDTH_8/16/32 codes.
  - WB_IDLE/WB_MEM0/WB_MEM1/WB_RETIRE state encodings.
  - EFLAGS_RESET value.
- One combinational sub-module, gpr_merge:
  - Inputs: old register value, new value, width, hi8 flag.
  - Output: merged value.
  - Instantiated twice, for dest1 and dest0.

Test Plan:
- Reset then idle -> eip=RESET_EIP, eflags=32'h2, gpr_flat all 0 except ESP=RESET_ESP, in_ready=1, retire_count=0.
- REG-only commit (dest0 REG sel=0 width32 opnd0_w=32'hDEAD_BEEF, eflags_in=32'h0000_0041, next_eip=32'h1005) -> EAX=32'hDEADBEEF, eflags=32'h43, eip=32'h1005; retired pulses once; retire_count=1.
- Partial write: EBX=32'h1122_3344, dest0 REG sel=7 width8 opnd0_w=32'hAA -> EBX=32'h1122_AA44. Repeat with sel=3 width16 opnd0_w=32'h5566 -> EBX=32'h1122_5566.
- CALL-style commit (dest0 MEM addr=32'h0FFC width32 data=32'h2000; dest1 REG sel=4 width32 opnd1_w=32'h0FFC; mem_wr_ready held low 3 cycles) -> mem_wr_valid stable 4 cycles with addr=32'hFFC, mask=4'hF; ESP and EIP unchanged until the RETIRE edge, then ESP=32'hFFC.
- Two stores (dest0 MEM 8-bit at 32'h10, dest1 MEM 16-bit at 32'h20, ready tied high) -> back-to-back transfers with masks 4'b0001 then 4'b0011, then retire; in_ready low throughout.
- Same-register conflict (dest0 and dest1 both REG sel=2, values 32'h1 and 32'h2) -> EDX=32'h1. Reset asserted during a MEM0 stall -> mem_wr_valid=0 immediately, no retire, state equals the reset values.
